// File: rtl/tx_fifo_feed_module_pkg.sv
// Shared definitions for the UART transmit feed buffer: byte width,
// default FIFO geometry and the two-state sequencer encoding.
package tx_fifo_feed_module_pkg;
  localparam int BYTE_W    = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_AW    = 4;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_SEND = ST_SEND
  } state_t;
endpackage

// File: rtl/tx_fifo_feed_module_if.sv
// Application write side and transmit-stage handshake of the feed buffer.
// The overflow clear/flag pair only exists when TX_FEED_OVF_EN is defined.
interface tx_fifo_feed_module_if;
  import tx_fifo_feed_module_pkg::*;

  logic              Wr_En;
  logic [BYTE_W-1:0] Wr_Data;
  logic              Full;
  logic              Empty;
  logic              Busy;
  logic              Tx_Done_Sig;
  logic              Tx_En_Sig;
  logic [BYTE_W-1:0] Tx_Data;
`ifdef TX_FEED_OVF_EN
  logic              Ovf_Clr;
  logic              Ovf_Flag;
`endif

  // Application / transmit-stage side
  modport master (
    output Wr_En, Wr_Data, Tx_Done_Sig,
`ifdef TX_FEED_OVF_EN
    output Ovf_Clr,
    input  Ovf_Flag,
`endif
    input  Full, Empty, Busy, Tx_En_Sig, Tx_Data
  );

  // Feed buffer side
  modport slave (
    input  Wr_En, Wr_Data, Tx_Done_Sig,
`ifdef TX_FEED_OVF_EN
    input  Ovf_Clr,
    output Ovf_Flag,
`endif
    output Full, Empty, Busy, Tx_En_Sig, Tx_Data
  );
endinterface

// File: rtl/tx_fifo_feed_module_fifo.sv
// tx_feed_fifo: DEPTH-entry synchronous byte FIFO. Pushes while full are
// dropped; full is the registered count, so a same-cycle pop never makes
// room for the push.
module tx_feed_fifo
  import tx_fifo_feed_module_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);
  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp, rp;
  logic [AW:0]       cnt;
  logic              push_ok, pop_ok;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rp];

  // Storage is deliberately left unreset
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wp] <= push_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop_ok)  rp <= rp + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/tx_fifo_feed_module.sv
// tx_fifo_feed_module: buffers application bytes and presents them one at a
// time to the UART transmit stage, holding Tx_En_Sig/Tx_Data until
// Tx_Done_Sig. Optional sticky overflow flag under TX_FEED_OVF_EN.
module tx_fifo_feed_module
  import tx_fifo_feed_module_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  tx_fifo_feed_module_if.slave bus
);
  state_t            state, state_n;
  logic              pop;
  logic              fifo_full, fifo_empty;
  logic [BYTE_W-1:0] pop_data;
  logic [BYTE_W-1:0] tx_data_q;
  logic              tx_en_q;

  tx_feed_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .push      (bus.Wr_En),
    .push_data (bus.Wr_Data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state and pop decision; Done is ignored while idle
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.Tx_Done_Sig) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Registered transmit enable and byte; the byte only moves on a pop
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      tx_en_q <= (state_n == S_SEND);
      if (pop) tx_data_q <= pop_data;
    end
  end

  assign bus.Tx_En_Sig = tx_en_q;
  assign bus.Tx_Data   = tx_data_q;
  assign bus.Full      = fifo_full;
  assign bus.Empty     = fifo_empty;
  assign bus.Busy      = (state == S_SEND) || !fifo_empty;

`ifdef TX_FEED_OVF_EN
  logic ovf_q;

  // Sticky overflow: a new drop outranks a same-cycle clear
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)                      ovf_q <= 1'b0;
    else if (bus.Wr_En && fifo_full) ovf_q <= 1'b1;
    else if (bus.Ovf_Clr)            ovf_q <= 1'b0;
  end

  assign bus.Ovf_Flag = ovf_q;
`endif
endmodule

// File: tb/tb_tx_fifo_feed_module.sv
// Randomized and directed bench for tx_fifo_feed_module against a
// queue-based reference of the feed buffer behaviour.
module tb_tx_fifo_feed_module;
  localparam int DEPTH = 16;

  logic CLK = 1'b0;
  logic RST_n;
  always #5 CLK = ~CLK;

  tx_fifo_feed_module_if bus();

  tx_fifo_feed_module #(.DEPTH(DEPTH), .AW(4)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  int vectors = 0;
  int errs    = 0;

  // reference state
  logic [7:0] q[$];
  bit         m_en;
  logic [7:0] m_data;
  bit         m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_en   = 0;
    m_data = 8'h00;
    m_ovf  = 0;
  endtask

  task automatic cmp_all(input string pfx);
    chk({pfx, ".tx_en"},   {31'd0, bus.Tx_En_Sig}, {31'd0, m_en});
    chk({pfx, ".tx_data"}, {24'd0, bus.Tx_Data},   {24'd0, m_data});
    chk({pfx, ".full"},    {31'd0, bus.Full},      {31'd0, (q.size() == DEPTH)});
    chk({pfx, ".empty"},   {31'd0, bus.Empty},     {31'd0, (q.size() == 0)});
    chk({pfx, ".busy"},    {31'd0, bus.Busy},      {31'd0, (m_en || q.size() != 0)});
`ifdef TX_FEED_OVF_EN
    chk({pfx, ".ovf"},     {31'd0, bus.Ovf_Flag},  {31'd0, m_ovf});
`endif
  endtask

  // One clock: apply inputs, advance the reference, compare 1 ns after the edge
  task automatic step(input string pfx, input bit wr, input logic [7:0] d,
                      input bit done, input bit clr);
    bit full_b, empty_b;
    bus.Wr_En       = wr;
    bus.Wr_Data     = d;
    bus.Tx_Done_Sig = done;
`ifdef TX_FEED_OVF_EN
    bus.Ovf_Clr     = clr;
`endif
    @(posedge CLK);
    full_b  = (q.size() == DEPTH);
    empty_b = (q.size() == 0);
    if (clr)           m_ovf = 0;
    if (wr && full_b)  m_ovf = 1;
    if (!empty_b && (!m_en || done)) begin
      m_data = q.pop_front();
      m_en   = 1;
    end else if (m_en && done) begin
      m_en = 0;
    end
    if (wr && !full_b) q.push_back(d);
    #1;
    cmp_all(pfx);
    bus.Wr_En       = 1'b0;
    bus.Tx_Done_Sig = 1'b0;
`ifdef TX_FEED_OVF_EN
    bus.Ovf_Clr     = 1'b0;
`endif
  endtask

  task automatic drain(input string pfx);
    for (int i = 0; i < 400 && (m_en || q.size() != 0); i++)
      step(pfx, 0, 8'h00, (i % 3 == 2), 0);
    chk({pfx, ".drained_en"},    {31'd0, bus.Tx_En_Sig}, 32'd0);
    chk({pfx, ".drained_empty"}, {31'd0, bus.Empty},     32'd1);
  endtask

  initial begin
    bus.Wr_En       = 1'b0;
    bus.Wr_Data     = 8'h00;
    bus.Tx_Done_Sig = 1'b0;
`ifdef TX_FEED_OVF_EN
    bus.Ovf_Clr     = 1'b0;
`endif
    RST_n = 1'b0;
    model_reset();
    #1;
    cmp_all("reset");
    #11 RST_n = 1'b1;

    // single byte, late Done
    step("a5_wr", 1, 8'hA5, 0, 0);
    chk("a5_lat1_en", {31'd0, bus.Tx_En_Sig}, 32'd0);
    step("a5_wait", 0, 8'h00, 0, 0);
    chk("a5_data", {24'd0, bus.Tx_Data}, 32'hA5);
    chk("a5_en",   {31'd0, bus.Tx_En_Sig}, 32'd1);
    for (int i = 0; i < 19; i++) step("a5_hold", 0, 8'h00, 0, 0);
    step("a5_done", 1'b0, 8'h00, 1, 0);
    chk("a5_en_off", {31'd0, bus.Tx_En_Sig}, 32'd0);
    chk("a5_busy",   {31'd0, bus.Busy},      32'd0);

    // three back-to-back bytes
    step("seq_w1", 1, 8'h01, 0, 0);
    step("seq_w2", 1, 8'h02, 0, 0);
    step("seq_w3", 1, 8'h03, 0, 0);
    chk("seq_first", {24'd0, bus.Tx_Data}, 32'h01);
    for (int i = 0; i < 3; i++) begin
      step("seq_hold", 0, 8'h00, 0, 0);
      step("seq_done", 0, 8'h00, 1, 0);
    end
    chk("seq_en_off", {31'd0, bus.Tx_En_Sig}, 32'd0);

    // fill past capacity with no Done
    for (int i = 0; i < DEPTH + 2; i++) step("fill", 1, 8'(8'h40 + i), 0, 0);
    chk("fill_full", {31'd0, bus.Full}, 32'd1);
`ifdef TX_FEED_OVF_EN
    step("ovf_hold", 0, 8'h00, 0, 0);
    chk("ovf_set", {31'd0, bus.Ovf_Flag}, 32'd1);
    step("ovf_clr", 0, 8'h00, 0, 1);
    chk("ovf_cleared", {31'd0, bus.Ovf_Flag}, 32'd0);
    step("ovf_setwins", 1, 8'h77, 0, 1);
    chk("ovf_setwins", {31'd0, bus.Ovf_Flag}, 32'd1);
    step("ovf_clr2", 0, 8'h00, 0, 1);
`endif
    // write while full in the same cycle as Done: byte dropped, pop happens
    step("full_done", 1, 8'hEE, 1, 0);
    chk("full_done_full", {31'd0, bus.Full}, 32'd0);
    chk("full_done_data", {24'd0, bus.Tx_Data}, 32'h41);
    drain("full_drain");

    // wrap-around with 40 bytes
    for (int i = 0; i < 40; i++) step("wrap", 1, 8'(i), m_en && (i % 3 != 0), 0);
    drain("wrap_drain");

    // async reset mid-transmission with 5 queued
    for (int i = 0; i < 6; i++) step("rst_fill", 1, 8'(8'h90 + i), 0, 0);
    chk("rst_pre_en", {31'd0, bus.Tx_En_Sig}, 32'd1);
    #2 RST_n = 1'b0;
    #1;
    model_reset();
    chk("rst_en_drop", {31'd0, bus.Tx_En_Sig}, 32'd0);
    chk("rst_empty",   {31'd0, bus.Empty},     32'd1);
    @(posedge CLK);
    #1 RST_n = 1'b1;
    cmp_all("rst_rel");
    step("rst_3c_wr", 1, 8'h3C, 0, 0);
    step("rst_3c_go", 0, 8'h00, 0, 0);
    chk("rst_3c_data", {24'd0, bus.Tx_Data}, 32'h3C);
    drain("rst_drain");

    // random traffic
    for (int i = 0; i < 2000; i++)
      step("rnd", 1'($urandom_range(0, 1)), 8'($urandom),
           m_en ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 15) == 0));
    drain("rnd_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
